// File: rtl/calc_tag_tracker.sv
// Per-port, per-tag outstanding-request tracker with duplicate, orphan and timeout detection.
// Optional ageing/timeout logic is enabled with `define CALC_TRK_TIMEOUT_EN.
module calc_tag_tracker #(
  parameter int NUM_PORTS      = 4,
  parameter int CMD_WIDTH      = 4,
  parameter int TAG_WIDTH      = 2,
  parameter int RESP_WIDTH     = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ERR_CNT_WIDTH  = 16
) (
  input  logic                                  ifClk,
  input  logic                                  ifRst,
  input  logic [NUM_PORTS*CMD_WIDTH-1:0]        req_cmd,
  input  logic [NUM_PORTS*TAG_WIDTH-1:0]        req_tag,
  input  logic [NUM_PORTS*RESP_WIDTH-1:0]       resp,
  input  logic [NUM_PORTS*TAG_WIDTH-1:0]        resp_tag,
  output logic [NUM_PORTS*(2**TAG_WIDTH)-1:0]   outstanding,
  output logic [NUM_PORTS*(TAG_WIDTH+1)-1:0]    out_count,
  output logic [NUM_PORTS-1:0]                  err_dup,
  output logic [NUM_PORTS-1:0]                  err_orphan,
  output logic [NUM_PORTS-1:0]                  err_timeout,
  output logic [ERR_CNT_WIDTH-1:0]              err_count,
  output logic                                  idle
);

  localparam int DEPTH = 2**TAG_WIDTH;
  localparam int NENT  = NUM_PORTS*DEPTH;
  localparam int EV_W  = $clog2(NUM_PORTS*(DEPTH+2)+1);
  localparam int SUM_W = ERR_CNT_WIDTH + EV_W;

  logic [NENT-1:0]          valid_q, valid_d;
  logic [NUM_PORTS-1:0]     dup_d, orph_d, to_d;
  logic [EV_W-1:0]          events;
  logic [SUM_W-1:0]         sum;
  logic [ERR_CNT_WIDTH-1:0] cnt_d;

`ifdef CALC_TRK_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT_CYCLES);
  logic [AGE_W-1:0] age_q [NENT];
  logic [AGE_W-1:0] age_d [NENT];
`endif

  always_comb begin
    logic issue, rsp, hit_i, hit_r;
    logic [TAG_WIDTH-1:0] it, rt;
    int unsigned idx;
    valid_d = valid_q;
    dup_d   = '0;
    orph_d  = '0;
    to_d    = '0;
    events  = '0;
`ifdef CALC_TRK_TIMEOUT_EN
    age_d   = age_q;
`endif
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      issue = |req_cmd[p*CMD_WIDTH +: CMD_WIDTH];
      rsp   = |resp[p*RESP_WIDTH +: RESP_WIDTH];
      it    = req_tag[p*TAG_WIDTH +: TAG_WIDTH];
      rt    = resp_tag[p*TAG_WIDTH +: TAG_WIDTH];
      for (int unsigned t = 0; t < DEPTH; t++) begin
        idx   = p*DEPTH + t;
        hit_i = issue && (it == TAG_WIDTH'(t));
        hit_r = rsp && (rt == TAG_WIDTH'(t));
        if (hit_r && !valid_q[idx]) orph_d[p] = 1'b1;
        // Issue dominates: a same-cycle response only retires the old entry, and a
        // reissue on a live tag restarts its age instead of letting it expire.
        if (hit_i) begin
          if (valid_q[idx] && !hit_r) dup_d[p] = 1'b1;
          valid_d[idx] = 1'b1;
`ifdef CALC_TRK_TIMEOUT_EN
          age_d[idx] = '0;
`endif
        end else if (hit_r) begin
          valid_d[idx] = 1'b0;
        end else if (valid_q[idx]) begin
`ifdef CALC_TRK_TIMEOUT_EN
          if (age_q[idx] == AGE_W'(TIMEOUT_CYCLES-1)) begin
            valid_d[idx] = 1'b0;
            to_d[p]      = 1'b1;
            events       = events + EV_W'(1);
          end else begin
            age_d[idx] = age_q[idx] + AGE_W'(1);
          end
`endif
        end
      end
      events = events + EV_W'(dup_d[p]) + EV_W'(orph_d[p]);
    end
    sum   = SUM_W'(err_count) + SUM_W'(events);
    cnt_d = (|sum[SUM_W-1:ERR_CNT_WIDTH]) ? '1 : sum[ERR_CNT_WIDTH-1:0];
  end

  always_ff @(posedge ifClk or negedge ifRst) begin
    if (!ifRst) begin
      valid_q     <= '0;
      err_dup     <= '0;
      err_orphan  <= '0;
      err_timeout <= '0;
      err_count   <= '0;
    end else begin
      valid_q     <= valid_d;
      err_dup     <= dup_d;
      err_orphan  <= orph_d;
      err_timeout <= to_d;
      err_count   <= cnt_d;
    end
  end

`ifdef CALC_TRK_TIMEOUT_EN
  always_ff @(posedge ifClk or negedge ifRst) begin
    if (!ifRst) begin
      for (int unsigned i = 0; i < NENT; i++) age_q[i] <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`endif

  always_comb begin
    out_count = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++)
      for (int unsigned t = 0; t < DEPTH; t++)
        out_count[p*(TAG_WIDTH+1) +: TAG_WIDTH+1] =
          out_count[p*(TAG_WIDTH+1) +: TAG_WIDTH+1] + (TAG_WIDTH+1)'(valid_q[p*DEPTH+t]);
  end

  assign outstanding = valid_q;
  assign idle        = ~|valid_q;

endmodule

// File: tb/tb_calc_tag_tracker.sv
// Scoreboard bench for calc_tag_tracker: directed vectors push hand-computed expectations,
// a monitor pops and compares one expectation per cycle after the sampling edge.
module tb_calc_tag_tracker;
  localparam int NP = 4, CW = 4, TW = 2, RW = 2, T = 8, EW = 4;

  logic                 ifClk = 1'b0;
  logic                 ifRst = 1'b0;
  logic [NP*CW-1:0]     req_cmd  = '0;
  logic [NP*TW-1:0]     req_tag  = '0;
  logic [NP*RW-1:0]     resp     = '0;
  logic [NP*TW-1:0]     resp_tag = '0;
  logic [NP*4-1:0]      outstanding;
  logic [NP*(TW+1)-1:0] out_count;
  logic [NP-1:0]        err_dup, err_orphan, err_timeout;
  logic [EW-1:0]        err_count;
  logic                 idle;

  calc_tag_tracker #(
    .NUM_PORTS(NP), .CMD_WIDTH(CW), .TAG_WIDTH(TW), .RESP_WIDTH(RW),
    .TIMEOUT_CYCLES(T), .ERR_CNT_WIDTH(EW)
  ) dut (
    .ifClk(ifClk), .ifRst(ifRst), .req_cmd(req_cmd), .req_tag(req_tag),
    .resp(resp), .resp_tag(resp_tag), .outstanding(outstanding), .out_count(out_count),
    .err_dup(err_dup), .err_orphan(err_orphan), .err_timeout(err_timeout),
    .err_count(err_count), .idle(idle)
  );

  always #5 ifClk = ~ifClk;

  typedef struct packed {
    logic [15:0] outst;
    logic [3:0]  dup;
    logic [3:0]  orph;
    logic [3:0]  to;
    logic [3:0]  cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  initial begin
    exp_t  e;
    string nm;
    logic [11:0] ec;
    logic        ei;
    forever begin
      @(posedge ifClk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        ec = '0;
        for (int p = 0; p < NP; p++)
          for (int t = 0; t < 4; t++)
            ec[p*3 +: 3] = ec[p*3 +: 3] + 3'(e.outst[p*4+t]);
        ei = (e.outst == 16'h0);
        vectors++;
        if (outstanding !== e.outst || out_count !== ec || err_dup !== e.dup ||
            err_orphan !== e.orph || err_timeout !== e.to || err_count !== e.cnt || idle !== ei) begin
          miscompares++;
          $display("FAIL %s: outstanding=%h exp %h, out_count=%h exp %h, dup=%b exp %b, orphan=%b exp %b, timeout=%b exp %b, err_count=%0d exp %0d, idle=%b exp %b",
                   nm, outstanding, e.outst, out_count, ec, err_dup, e.dup, err_orphan, e.orph,
                   err_timeout, e.to, err_count, e.cnt, idle, ei);
        end
      end
    end
  end

  task automatic step(input string nm, input logic [15:0] c, input logic [7:0] tg,
                      input logic [7:0] r, input logic [7:0] rt, input logic [15:0] eo,
                      input logic [3:0] ed, input logic [3:0] eor, input logic [3:0] eto,
                      input logic [3:0] ecnt);
    exp_t e;
    @(negedge ifClk);
    req_cmd = c; req_tag = tg; resp = r; resp_tag = rt;
    e.outst = eo; e.dup = ed; e.orph = eor; e.to = eto; e.cnt = ecnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle_step(input string nm, input logic [15:0] eo, input logic [3:0] ecnt);
    step(nm, 16'h0, 8'h0, 8'h0, 8'h0, eo, 4'h0, 4'h0, 4'h0, ecnt);
  endtask

  task automatic do_reset();
    @(negedge ifClk);
    ifRst = 1'b0;
    req_cmd = '0; req_tag = '0; resp = '0; resp_tag = '0;
    repeat (2) @(negedge ifClk);
    ifRst = 1'b1;
  endtask

  initial begin
    do_reset();
    // basic issue / response
    idle_step("reset_state", 16'h0000, 4'd0);
    step("a_issue", 16'h0001, 8'h02, 8'h00, 8'h00, 16'h0004, 4'h0, 4'h0, 4'h0, 4'd0);
    idle_step("a_hold1", 16'h0004, 4'd0);
    idle_step("a_hold2", 16'h0004, 4'd0);
    step("a_resp", 16'h0000, 8'h00, 8'h01, 8'h02, 16'h0000, 4'h0, 4'h0, 4'h0, 4'd0);
    idle_step("a_idle", 16'h0000, 4'd0);
    // duplicate on port1 tag0
    step("b_issue", 16'h0010, 8'h00, 8'h00, 8'h00, 16'h0010, 4'h0, 4'h0, 4'h0, 4'd0);
    step("b_dup", 16'h0010, 8'h00, 8'h00, 8'h00, 16'h0010, 4'b0010, 4'h0, 4'h0, 4'd1);
    idle_step("b_after", 16'h0010, 4'd1);
    step("b_resp", 16'h0000, 8'h00, 8'h04, 8'h00, 16'h0000, 4'h0, 4'h0, 4'h0, 4'd1);
    // orphan on port3 tag1
    step("c_orphan", 16'h0000, 8'h00, 8'h80, 8'h40, 16'h0000, 4'h0, 4'b1000, 4'h0, 4'd2);
    idle_step("c_after", 16'h0000, 4'd2);
    // port2 tag3 issue, then same-cycle issue+response
    step("d_issue", 16'h0100, 8'h30, 8'h00, 8'h00, 16'h0800, 4'h0, 4'h0, 4'h0, 4'd2);
    step("d_reissue", 16'h0100, 8'h30, 8'h10, 8'h30, 16'h0800, 4'h0, 4'h0, 4'h0, 4'd2);
`ifdef CALC_TRK_TIMEOUT_EN
    for (int i = 0; i < 7; i++) idle_step("d_age", 16'h0800, 4'd2);
    step("d_timeout", 16'h0, 8'h0, 8'h0, 8'h0, 16'h0000, 4'h0, 4'h0, 4'b0100, 4'd3);
    idle_step("d_after", 16'h0000, 4'd3);
`else
    for (int i = 0; i < 10; i++) idle_step("d_noage", 16'h0800, 4'd2);
    step("d_resp", 16'h0000, 8'h00, 8'h10, 8'h30, 16'h0000, 4'h0, 4'h0, 4'h0, 4'd2);
`endif
    // saturation: 4 orphans per cycle for 5 cycles
    do_reset();
    step("f_orph4", 16'h0, 8'h0, 8'h55, 8'h00, 16'h0, 4'h0, 4'b1111, 4'h0, 4'd4);
    step("f_orph8", 16'h0, 8'h0, 8'h55, 8'h00, 16'h0, 4'h0, 4'b1111, 4'h0, 4'd8);
    step("f_orph12", 16'h0, 8'h0, 8'h55, 8'h00, 16'h0, 4'h0, 4'b1111, 4'h0, 4'd12);
    step("f_sat16", 16'h0, 8'h0, 8'h55, 8'h00, 16'h0, 4'h0, 4'b1111, 4'h0, 4'd15);
    step("f_sat20", 16'h0, 8'h0, 8'h55, 8'h00, 16'h0, 4'h0, 4'b1111, 4'h0, 4'd15);
    idle_step("f_hold", 16'h0000, 4'd15);
    // mid-stream reset with five entries outstanding
    do_reset();
    step("g_issue4", 16'h1111, 8'h00, 8'h00, 8'h00, 16'h1111, 4'h0, 4'h0, 4'h0, 4'd0);
    step("g_issue5", 16'h0001, 8'h01, 8'h00, 8'h00, 16'h1113, 4'h0, 4'h0, 4'h0, 4'd0);
    @(negedge ifClk);
    ifRst = 1'b0;
    req_cmd = '0; req_tag = '0; resp = '0; resp_tag = '0;
    #1;
    vectors++;
    if (outstanding !== '0 || idle !== 1'b1 || err_count !== '0 ||
        err_dup !== '0 || err_orphan !== '0 || err_timeout !== '0) begin
      miscompares++;
      $display("FAIL g_async_reset: outstanding=%h idle=%b err_count=%0d dup=%b orphan=%b timeout=%b, required 0000/1/0/0000/0000/0000",
               outstanding, idle, err_count, err_dup, err_orphan, err_timeout);
    end
    repeat (2) @(negedge ifClk);
    ifRst = 1'b1;
    idle_step("g_post", 16'h0000, 4'd0);
    // same-cycle combinations and multi-port errors
    step("h_issue", 16'h0001, 8'h01, 8'h00, 8'h00, 16'h0002, 4'h0, 4'h0, 4'h0, 4'd0);
    step("h_difftag", 16'h0001, 8'h02, 8'h01, 8'h01, 16'h0004, 4'h0, 4'h0, 4'h0, 4'd0);
    step("h_orph_set", 16'h0010, 8'h0C, 8'h04, 8'h0C, 16'h0084, 4'h0, 4'b0010, 4'h0, 4'd1);
    step("h_multi", 16'h0011, 8'h0E, 8'h10, 8'h00, 16'h0084, 4'b0011, 4'b0100, 4'h0, 4'd4);
    idle_step("h_after", 16'h0084, 4'd4);
`ifdef CALC_TRK_TIMEOUT_EN
    // two timeouts one cycle apart, then a response winning in its expiry cycle
    do_reset();
    step("e_t0", 16'h0001, 8'h00, 8'h00, 8'h00, 16'h0001, 4'h0, 4'h0, 4'h0, 4'd0);
    step("e_t1", 16'h0001, 8'h01, 8'h00, 8'h00, 16'h0003, 4'h0, 4'h0, 4'h0, 4'd0);
    for (int i = 0; i < 6; i++) idle_step("e_age", 16'h0003, 4'd0);
    step("e_to0", 16'h0, 8'h0, 8'h0, 8'h0, 16'h0002, 4'h0, 4'h0, 4'b0001, 4'd1);
    step("e_to1", 16'h0, 8'h0, 8'h0, 8'h0, 16'h0000, 4'h0, 4'h0, 4'b0001, 4'd2);
    idle_step("e_after", 16'h0000, 4'd2);
    do_reset();
    step("e2_t0", 16'h0001, 8'h00, 8'h00, 8'h00, 16'h0001, 4'h0, 4'h0, 4'h0, 4'd0);
    step("e2_t1", 16'h0001, 8'h01, 8'h00, 8'h00, 16'h0003, 4'h0, 4'h0, 4'h0, 4'd0);
    for (int i = 0; i < 6; i++) idle_step("e2_age", 16'h0003, 4'd0);
    step("e2_to0", 16'h0, 8'h0, 8'h0, 8'h0, 16'h0002, 4'h0, 4'h0, 4'b0001, 4'd1);
    step("e2_resp_wins", 16'h0, 8'h0, 8'h01, 8'h01, 16'h0000, 4'h0, 4'h0, 4'h0, 4'd1);
    idle_step("e2_after", 16'h0000, 4'd1);
`endif
    begin
      int waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
        @(posedge ifClk);
        waited++;
      end
      repeat (2) @(posedge ifClk);
      if (exp_q.size() > 0) begin
        miscompares++;
        $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
